// File: rtl/operand_loader_pkg.sv
// Shared types and default parameters for the operand entry unit.
package operand_loader_pkg;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_AUTO   = 1'b1
    } mode_e;

    localparam int unsigned DEF_WIDTH           = 8;
    localparam int unsigned DEF_NUM_OPS         = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button conditioning: 2-FF synchroniser, stability counter, registered rise flag.
module btn_debounce
    import operand_loader_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_stable,
    output logic btn_rise
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]       sync_q;
    logic             synced;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_d;
    logic             rise_d;

    assign synced = sync_q[1];

    // Level change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        cnt_d    = '0;
        stable_d = btn_stable;
        rise_d   = 1'b0;
        if (synced != btn_stable) begin
            if (cnt_q + CNT_W'(1) == CNT_W'(DEBOUNCE_CYCLES)) begin
                stable_d = synced;
                rise_d   = synced;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            cnt_q      <= '0;
            btn_stable <= 1'b0;
            btn_rise   <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], btn_raw};
            cnt_q      <= cnt_d;
            btn_stable <= stable_d;
            btn_rise   <= rise_d;
        end
    end

endmodule

// File: rtl/operand_loader.sv
// Operand entry unit: debounced load button writes switch data into manual- or auto-selected registers.
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int unsigned WIDTH           = DEF_WIDTH,
    parameter int unsigned NUM_OPS         = DEF_NUM_OPS,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned IDX_W           = $clog2(NUM_OPS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     btn_load,
    input  logic                     clr,
    input  logic                     mode,
    input  logic [IDX_W-1:0]         sel,
    input  logic [WIDTH-1:0]         data_in,
    output logic [NUM_OPS*WIDTH-1:0] operands,
    output logic [IDX_W-1:0]         ptr,
    output logic [NUM_OPS-1:0]       loaded_mask,
    output logic                     all_loaded,
    output logic                     load_pulse
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPS - 1);

    logic                            btn_stable;
    logic                            btn_rise;
    logic                            load_req;
    logic                            sel_ok;
    logic [NUM_OPS-1:0][WIDTH-1:0]   ops_q, ops_d;
    logic [IDX_W-1:0]                ptr_d;
    logic [NUM_OPS-1:0]              mask_d;
    logic                            all_d;
    logic                            pulse_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_load (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (btn_load),
        .btn_stable(btn_stable),
        .btn_rise  (btn_rise)
    );

    // Rise is only meaningful while the debounced level is high.
    assign load_req = btn_rise & btn_stable;
    assign sel_ok   = {1'b0, sel} < (IDX_W + 1)'(NUM_OPS);
    assign operands = ops_q;

    always_comb begin
        ops_d   = ops_q;
        mask_d  = loaded_mask;
        ptr_d   = ptr;
        pulse_d = 1'b0;
        if (clr) begin
            ops_d  = '0;
            mask_d = '0;
            ptr_d  = '0;
        end else if (load_req) begin
            if (mode_e'(mode) == MODE_AUTO) begin
                ops_d[ptr]  = data_in;
                mask_d[ptr] = 1'b1;
                pulse_d     = 1'b1;
                ptr_d       = (ptr == LAST_IDX) ? '0 : ptr + IDX_W'(1);
            end else if (sel_ok) begin
                ops_d[sel]  = data_in;
                mask_d[sel] = 1'b1;
                pulse_d     = 1'b1;
            end
        end
        all_d = &mask_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_q       <= '0;
            ptr         <= '0;
            loaded_mask <= '0;
            all_loaded  <= 1'b0;
            load_pulse  <= 1'b0;
        end else begin
            ops_q       <= ops_d;
            ptr         <= ptr_d;
            loaded_mask <= mask_d;
            all_loaded  <= all_d;
            load_pulse  <= pulse_d;
        end
    end

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader: 2x8-bit instance plus a 3x12-bit instance, debounce of 4 cycles.
module tb_operand_loader;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        btn_load, clr, mode;
    logic [0:0]  sel;
    logic [7:0]  data_in;
    logic [15:0] operands;
    logic [0:0]  ptr;
    logic [1:0]  loaded_mask;
    logic        all_loaded, load_pulse;

    logic        btn3, clr3, mode3;
    logic [1:0]  sel3;
    logic [11:0] data3;
    logic [35:0] operands3;
    logic [1:0]  ptr3;
    logic [2:0]  mask3;
    logic        all3, pulse3;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int pulses3 = 0;
    int p0;

    always #5 clk = ~clk;

    operand_loader #(.WIDTH(8), .NUM_OPS(2), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .btn_load(btn_load), .clr(clr), .mode(mode),
        .sel(sel), .data_in(data_in), .operands(operands), .ptr(ptr),
        .loaded_mask(loaded_mask), .all_loaded(all_loaded), .load_pulse(load_pulse)
    );

    operand_loader #(.WIDTH(12), .NUM_OPS(3), .DEBOUNCE_CYCLES(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .btn_load(btn3), .clr(clr3), .mode(mode3),
        .sel(sel3), .data_in(data3), .operands(operands3), .ptr(ptr3),
        .loaded_mask(mask3), .all_loaded(all3), .load_pulse(pulse3)
    );

    always @(negedge clk) begin
        if (load_pulse) pulses++;
        if (pulse3) pulses3++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [7:0] d, input int hold);
        data_in  = d;
        btn_load = 1'b1;
        tick(hold);
        btn_load = 1'b0;
        tick(10);
    endtask

    task automatic press3(input logic [11:0] d);
        data3 = d;
        btn3  = 1'b1;
        tick(10);
        btn3  = 1'b0;
        tick(10);
    endtask

    initial begin
        rst_n = 1'b0; btn_load = 1'b1; clr = 1'b0; mode = 1'b0; sel = 1'b1; data_in = 8'hA5;
        btn3 = 1'b0; clr3 = 1'b0; mode3 = 1'b0; sel3 = 2'd0; data3 = 12'h0;
        tick(3);
        check("rst_operands", 64'(operands), 64'h0);
        check("rst_ptr", 64'(ptr), 64'h0);
        check("rst_mask", 64'(loaded_mask), 64'h0);
        check("rst_pulse", 64'(load_pulse), 64'h0);
        check("rst_all", 64'(all_loaded), 64'h0);

        // Release with button already held: write lands on edge 7 after first sample.
        @(negedge clk) rst_n = 1'b1;
        tick(6);
        check("lat_e6_pulse", 64'(load_pulse), 64'h0);
        check("lat_e6_mask", 64'(loaded_mask), 64'h0);
        tick(1);
        check("lat_e7_pulse", 64'(load_pulse), 64'h1);
        check("man_op", 64'(operands), 64'hA500);
        check("man_mask", 64'(loaded_mask), 64'h2);
        check("man_ptr", 64'(ptr), 64'h0);
        check("man_all0", 64'(all_loaded), 64'h0);
        tick(8);
        btn_load = 1'b0;
        tick(10);
        check("hold_one_pulse", 64'(pulses), 64'd1);

        sel = 1'b0;
        press(8'h3C, 10);
        check("man2_op", 64'(operands), 64'hA53C);
        check("man2_all", 64'(all_loaded), 64'h1);
        check("man2_pulses", 64'(pulses), 64'd2);

        mode = 1'b1;
        press(8'h11, 10);
        check("auto1_op", 64'(operands), 64'hA511);
        check("auto1_ptr", 64'(ptr), 64'h1);
        press(8'h22, 10);
        check("auto2_op", 64'(operands), 64'h2211);
        check("auto2_ptr", 64'(ptr), 64'h0);
        press(8'h33, 10);
        check("auto3_op", 64'(operands), 64'h2233);
        check("auto3_ptr", 64'(ptr), 64'h1);
        check("auto3_mask", 64'(loaded_mask), 64'h3);

        // Bouncing press: short highs never settle, the final long hold does.
        p0 = pulses;
        data_in = 8'h44;
        for (int i = 0; i < 3; i++) begin
            btn_load = 1'b1; tick(3);
            btn_load = 1'b0; tick(2);
        end
        btn_load = 1'b1; tick(10);
        btn_load = 1'b0; tick(10);
        check("bounce_pulses", 64'(pulses - p0), 64'd1);
        check("bounce_op", 64'(operands), 64'h4433);
        check("bounce_ptr", 64'(ptr), 64'h0);

        p0 = pulses;
        data_in = 8'h99;
        btn_load = 1'b1; tick(3);
        btn_load = 1'b0; tick(10);
        check("glitch_pulses", 64'(pulses - p0), 64'd0);
        check("glitch_op", 64'(operands), 64'h4433);

        press(8'h55, 10);
        check("pre_clr_op", 64'(operands), 64'h4455);
        check("pre_clr_ptr", 64'(ptr), 64'h1);

        // clr coincides with the load request cycle; the load must be dropped.
        p0 = pulses;
        data_in = 8'h66;
        btn_load = 1'b1;
        tick(6);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("clr_op", 64'(operands), 64'h0);
        check("clr_mask", 64'(loaded_mask), 64'h0);
        check("clr_ptr", 64'(ptr), 64'h0);
        check("clr_pulse", 64'(load_pulse), 64'h0);
        check("clr_all", 64'(all_loaded), 64'h0);
        tick(5);
        btn_load = 1'b0;
        tick(10);
        check("clr_dropped", 64'(pulses - p0), 64'd0);
        check("clr_op_after", 64'(operands), 64'h0);

        mode = 1'b0; sel = 1'b0;
        press(8'h77, 10);
        check("pre_rst_op", 64'(operands), 64'h0077);

        // Async reset in the middle of a debounce.
        p0 = pulses;
        btn_load = 1'b1;
        tick(4);
        rst_n = 1'b0;
        #1;
        check("arst_op", 64'(operands), 64'h0);
        check("arst_mask", 64'(loaded_mask), 64'h0);
        btn_load = 1'b0;
        tick(2);
        @(negedge clk) rst_n = 1'b1;
        tick(15);
        check("arst_no_write", 64'(pulses - p0), 64'd0);
        check("arst_mask_after", 64'(loaded_mask), 64'h0);

        // Three-operand instance: out-of-range manual select, then a full auto sweep.
        mode3 = 1'b0; sel3 = 2'd3;
        press3(12'hABC);
        check("n3_sel3_pulses", 64'(pulses3), 64'd0);
        check("n3_sel3_mask", 64'(mask3), 64'h0);
        check("n3_sel3_op", 64'(operands3), 64'h0);
        mode3 = 1'b1;
        press3(12'h101);
        check("n3_ptr1", 64'(ptr3), 64'h1);
        press3(12'h202);
        check("n3_ptr2", 64'(ptr3), 64'h2);
        check("n3_all_partial", 64'(all3), 64'h0);
        press3(12'h303);
        check("n3_ptr_wrap", 64'(ptr3), 64'h0);
        check("n3_mask", 64'(mask3), 64'h7);
        check("n3_all", 64'(all3), 64'h1);
        check("n3_op", 64'(operands3), 64'h303202101);
        check("n3_pulses", 64'(pulses3), 64'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
